// File: rtl/sw_ram_writer_pkg.sv
// Shared constants and FSM state type for the switch-driven RAM write stage.
// Default sizes match the 32x8 LPM RAM on the DE2 board and a 10 ms debounce at 50 MHz.
package sw_ram_pkg;

   localparam int ADDR_W_DEF          = 5;
   localparam int DATA_W_DEF          = 8;
   localparam int DEBOUNCE_CYCLES_DEF = 500000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2
   } state_e;

endpackage

// File: rtl/sw_ram_writer_debounce.sv
// 2-flop synchroniser plus stable-count debouncer for one raw slide switch.
// Emits the accepted level and a one-cycle pulse on each accepted off->on change.
module sw_debounce
   import sw_ram_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // The level flips on the sample that completes a run of DEBOUNCE_CYCLES disagreeing samples.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sw_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/sw_ram_writer.sv
// Turns DE2 slide switches into registered RAM address/data/wren with one write per switch toggle.
// Define SW_RAM_CLEAR_EN to build the sw_clr-triggered zero-fill sequencer (busy is 0 otherwise).
module sw_ram_writer
   import sw_ram_pkg::*;
#(
   parameter int ADDR_W          = ADDR_W_DEF,
   parameter int DATA_W          = DATA_W_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic [ADDR_W-1:0] sw_addr,
   input  logic [DATA_W-1:0] sw_data,
   input  logic              sw_wr,
   input  logic              sw_clr,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] address_q, address_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wren_q, wren_d;
   logic              busy_q, busy_d;
   logic              wr_evt;
   logic              wr_level_unused;

   sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_db (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .sw_in (sw_wr),
      .level (wr_level_unused),
      .rise  (wr_evt)
   );

`ifdef SW_RAM_CLEAR_EN
   logic clr_evt;
   logic clr_level_unused;

   sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .sw_in (sw_clr),
      .level (clr_level_unused),
      .rise  (clr_evt)
   );
`else
   logic sw_clr_unused;
   assign sw_clr_unused = sw_clr;
`endif

   always_comb begin
      state_d   = state_q;
      address_d = address_q;
      data_d    = data_q;
      wren_d    = 1'b0;
      busy_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            address_d = sw_addr;
            data_d    = sw_data;
            if (wr_evt) begin
               state_d = WRITE;
               wren_d  = 1'b1;
            end
`ifdef SW_RAM_CLEAR_EN
            // Evaluated last so a same-cycle clear overrides a write.
            if (clr_evt) begin
               state_d   = CLEAR;
               address_d = '0;
               data_d    = '0;
               wren_d    = 1'b1;
               busy_d    = 1'b1;
            end
`endif
         end
         WRITE: begin
            state_d   = IDLE;
            address_d = sw_addr;
            data_d    = sw_data;
         end
`ifdef SW_RAM_CLEAR_EN
         CLEAR: begin
            if (address_q == ADDR_LAST) begin
               state_d   = IDLE;
               address_d = sw_addr;
               data_d    = sw_data;
            end else begin
               address_d = address_q + 1'b1;
               data_d    = '0;
               wren_d    = 1'b1;
               busy_d    = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state_q   <= IDLE;
         address_q <= '0;
         data_q    <= '0;
         wren_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         address_q <= address_d;
         data_q    <= data_d;
         wren_q    <= wren_d;
         busy_q    <= busy_d;
      end
   end

   assign address = address_q;
   assign data    = data_q;
   assign wren    = wren_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_sw_ram_writer.sv
// Self-checking bench for sw_ram_writer with DEBOUNCE_CYCLES = 4; clear tests run when SW_RAM_CLEAR_EN is defined.
// A window-based switch model predicts outputs every cycle; directed phases pin latencies and RAM contents.
`timescale 1ns/1ps
module tb_sw_ram_writer;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;
   localparam int DB     = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              CLOCK_50 = 1'b0;
   logic              RESET_N;
   logic [ADDR_W-1:0] sw_addr;
   logic [DATA_W-1:0] sw_data;
   logic              sw_wr;
   logic              sw_clr;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic              busy;

   int assert_count = 0;
   int fail_count   = 0;

   sw_ram_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DB)) dut (
      .CLOCK_50 (CLOCK_50),
      .RESET_N  (RESET_N),
      .sw_addr  (sw_addr),
      .sw_data  (sw_data),
      .sw_wr    (sw_wr),
      .sw_clr   (sw_clr),
      .address  (address),
      .data     (data),
      .wren     (wren),
      .busy     (busy)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input logic wr, input logic clr);
      sw_addr = a;
      sw_data = d;
      sw_wr   = wr;
      sw_clr  = clr;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   task automatic waitHigh(input bit want_busy, input int limit, output int cycles);
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         @(posedge CLOCK_50);
         #1;
         if ((want_busy ? busy : wren) === 1'b1) begin
            cycles = i;
            return;
         end
      end
   endtask

   // RAM stand-in fed by the DUT outputs, plus write/clear activity counters.
   logic [DATA_W-1:0] ram [DEPTH] = '{default: 8'hC3};
   int                wr_pulses   = 0;
   int                busy_cycles = 0;
   logic [ADDR_W-1:0] last_wr_addr = '0;
   logic [DATA_W-1:0] last_wr_data = '0;

   always @(posedge CLOCK_50) begin
      if (wren === 1'b1) ram[address] <= data;
      if (wren === 1'b1 && busy !== 1'b1) begin
         wr_pulses    <= wr_pulses + 1;
         last_wr_addr <= address;
         last_wr_data <= data;
      end
      if (busy === 1'b1) busy_cycles <= busy_cycles + 1;
   end

   // Reference model: a switch level is accepted once the last DB samples (taken two
   // cycles late) all disagree with it; accepted rises start a write or a full clear.
   bit [DB-1:0]       m_win   [2];
   int                m_valid [2];
   bit                m_lvl   [2];
   bit                m_rise  [2];
   bit                m_d0    [2];
   bit                m_d1    [2];
   int                m_clear_idx = -1;
   bit                m_write     = 1'b0;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   bit                exp_wren;
   bit                exp_busy;

   always @(posedge CLOCK_50) begin
      bit raw [2];
      bit evt [2];
      bit s;
      raw[0] = sw_wr;
      raw[1] = sw_clr;
      if (!RESET_N) begin
         for (int ch = 0; ch < 2; ch++) begin
            m_win[ch]   = '0;
            m_valid[ch] = 0;
            m_lvl[ch]   = 1'b0;
            m_rise[ch]  = 1'b0;
            m_d0[ch]    = 1'b0;
            m_d1[ch]    = 1'b0;
         end
         m_clear_idx = -1;
         m_write     = 1'b0;
         exp_addr    = '0;
         exp_data    = '0;
         exp_wren    = 1'b0;
         exp_busy    = 1'b0;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            evt[ch]   = m_rise[ch];
            s         = m_d1[ch];
            m_d1[ch]  = m_d0[ch];
            m_d0[ch]  = raw[ch];
            m_win[ch] = {m_win[ch][DB-2:0], s};
            if (m_valid[ch] < DB) m_valid[ch]++;
            m_rise[ch] = 1'b0;
            if (m_valid[ch] == DB && m_win[ch] == {DB{~m_lvl[ch]}}) begin
               m_lvl[ch]  = ~m_lvl[ch];
               m_rise[ch] = m_lvl[ch];
            end
         end
`ifndef SW_RAM_CLEAR_EN
         evt[1] = 1'b0;
`endif
         if (m_clear_idx >= 0) begin
            if (m_clear_idx == DEPTH - 1) m_clear_idx = -1;
            else m_clear_idx++;
         end else if (m_write) begin
            m_write = 1'b0;
         end else if (evt[1]) begin
            m_clear_idx = 0;
         end else if (evt[0]) begin
            m_write = 1'b1;
         end
         if (m_clear_idx >= 0) begin
            exp_addr = m_clear_idx[ADDR_W-1:0];
            exp_data = '0;
            exp_wren = 1'b1;
            exp_busy = 1'b1;
         end else begin
            exp_addr = sw_addr;
            exp_data = sw_data;
            exp_wren = m_write;
            exp_busy = 1'b0;
         end
      end
      #1;
      checkOutput("model address", 32'(address), 32'(exp_addr));
      checkOutput("model data", 32'(data), 32'(exp_data));
      checkOutput("model wren", 32'(wren), 32'(exp_wren));
      checkOutput("model busy", 32'(busy), 32'(exp_busy));
   end

   task automatic writeWord(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      applyStimulus(a, d, 1'b1, 1'b0);
      waitCycles(12);
      applyStimulus(a, d, 1'b0, 1'b0);
      waitCycles(10);
   endtask

   initial begin
      int lat;
      int p0;
      int b0;
      RESET_N = 1'b0;
      applyStimulus('1, '1, 1'b1, 1'b1);
      repeat (3) @(posedge CLOCK_50);
      #1;
      checkOutput("reset address", 32'(address), 32'h0);
      checkOutput("reset data", 32'(data), 32'h0);
      checkOutput("reset wren", 32'(wren), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      waitCycles(1);
      applyStimulus('0, '0, 1'b0, 1'b0);
      RESET_N = 1'b1;
      waitCycles(10);

      $display("[TB] debounced write");
      p0 = wr_pulses;
      applyStimulus(5'h0A, 8'h3C, 1'b1, 1'b0);
      waitHigh(1'b0, 20, lat);
      checkOutput("write1 latency", 32'(lat), 32'd7);
      checkOutput("write1 address", 32'(address), 32'h0A);
      checkOutput("write1 data", 32'(data), 32'h3C);
      @(posedge CLOCK_50);
      #1;
      checkOutput("write1 single cycle", 32'(wren), 32'h0);
      waitCycles(15);
      checkOutput("write1 held pulses", 32'(wr_pulses - p0), 32'd1);
      applyStimulus(5'h0A, 8'h3C, 1'b0, 1'b0);
      waitCycles(10);
      checkOutput("switch-off pulses", 32'(wr_pulses - p0), 32'd1);
      applyStimulus(5'h0A, 8'h5A, 1'b1, 1'b0);
      waitHigh(1'b0, 20, lat);
      checkOutput("write2 latency", 32'(lat), 32'd7);
      checkOutput("write2 data", 32'(data), 32'h5A);
      waitCycles(15);
      checkOutput("write2 pulses", 32'(wr_pulses - p0), 32'd2);
      checkOutput("write2 ram", 32'(ram[5'h0A]), 32'h5A);

      $display("[TB] bounce rejection");
      applyStimulus(5'h12, 8'h99, 1'b0, 1'b0);
      waitCycles(10);
      p0 = wr_pulses;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(5'h12, 8'h99, (i % 2 == 0), 1'b0);
         waitCycles(2);
      end
      checkOutput("bounce no pulse", 32'(wr_pulses - p0), 32'd0);
      applyStimulus(5'h12, 8'h99, 1'b1, 1'b0);
      waitHigh(1'b0, 20, lat);
      checkOutput("bounce latency", 32'(lat), 32'd7);
      waitCycles(15);
      checkOutput("bounce pulses", 32'(wr_pulses - p0), 32'd1);
      checkOutput("bounce address", 32'(last_wr_addr), 32'h12);
      applyStimulus(5'h12, 8'h99, 1'b0, 1'b0);
      waitCycles(10);

`ifdef SW_RAM_CLEAR_EN
      $display("[TB] clear sweep");
      b0 = busy_cycles;
      applyStimulus(5'h03, 8'hAB, 1'b0, 1'b1);
      waitHigh(1'b1, 20, lat);
      checkOutput("clear latency", 32'(lat), 32'd7);
      for (int i = 0; i < DEPTH; i++) begin
         checkOutput("clear address", 32'(address), 32'(i));
         checkOutput("clear data", 32'(data), 32'h0);
         checkOutput("clear wren", 32'(wren), 32'h1);
         if (i < DEPTH - 1) begin
            @(posedge CLOCK_50);
            #1;
         end
      end
      @(posedge CLOCK_50);
      #1;
      checkOutput("clear end busy", 32'(busy), 32'h0);
      checkOutput("clear end wren", 32'(wren), 32'h0);
      checkOutput("clear busy cycles", 32'(busy_cycles - b0), 32'd32);
      checkOutput("clear ram 0A", 32'(ram[5'h0A]), 32'h00);
      checkOutput("clear ram 1F", 32'(ram[5'h1F]), 32'h00);
      checkOutput("clear ram 12", 32'(ram[5'h12]), 32'h00);
      waitCycles(1);
      applyStimulus(5'h03, 8'hAB, 1'b0, 1'b0);
      waitCycles(10);

      $display("[TB] simultaneous events");
      p0 = wr_pulses;
      b0 = busy_cycles;
      applyStimulus(5'h07, 8'h44, 1'b1, 1'b1);
      waitCycles(60);
      checkOutput("simul busy cycles", 32'(busy_cycles - b0), 32'd32);
      checkOutput("simul no write", 32'(wr_pulses - p0), 32'd0);
      applyStimulus(5'h07, 8'h44, 1'b0, 1'b0);
      waitCycles(10);

      $display("[TB] mid-clear reset");
      writeWord(5'h0A, 8'h55);
      writeWord(5'h0B, 8'h66);
      writeWord(5'h15, 8'h77);
      checkOutput("pre-abort ram 0B", 32'(ram[5'h0B]), 32'h66);
      applyStimulus(5'h00, 8'h00, 1'b0, 1'b1);
      waitHigh(1'b1, 20, lat);
      checkOutput("abort clear start", 32'(lat), 32'd7);
      for (int i = 0; i < 40 && address != 5'd10; i++) begin
         @(posedge CLOCK_50);
         #1;
      end
      checkOutput("abort address", 32'(address), 32'd10);
      waitCycles(1);
      RESET_N = 1'b0;
      applyStimulus(5'h00, 8'h00, 1'b0, 1'b0);
      @(posedge CLOCK_50);
      #1;
      checkOutput("abort busy", 32'(busy), 32'h0);
      checkOutput("abort wren", 32'(wren), 32'h0);
      checkOutput("abort ram 0A", 32'(ram[5'h0A]), 32'h00);
      checkOutput("abort ram 0B", 32'(ram[5'h0B]), 32'h66);
      checkOutput("abort ram 15", 32'(ram[5'h15]), 32'h77);
      waitCycles(2);
      RESET_N = 1'b1;
      waitCycles(10);
`else
      $display("[TB] clear compiled out");
      p0 = wr_pulses;
      b0 = busy_cycles;
      applyStimulus(5'h03, 8'h21, 1'b0, 1'b1);
      waitCycles(20);
      checkOutput("noclr busy cycles", 32'(busy_cycles - b0), 32'd0);
      checkOutput("noclr no wren", 32'(wr_pulses - p0), 32'd0);
      checkOutput("noclr ram 03", 32'(ram[5'h03]), 32'hC3);
      applyStimulus(5'h03, 8'h21, 1'b0, 1'b0);
      waitCycles(10);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
